sim_run_sequencer: RTL
======================

Name: sim_run_sequencer

Overview:
Parametrised run sequencer for simulation/bench tops; replaces hand-written clock-counter reset pulse and single-DUT finish polling. Drives an active-high DUT reset pulse at a programmable offset and length, then asserts run_req to up to CH compiled DUT channels. Latches each channel's finish flag, aggregates completion under a channel mask, and enforces a cycle watchdog. Synthesizable; sits between the bench clock/reset source and the DUT instances.

Parameters:
CH, 4, number of DUT channels (1..16)
RST_START, 4, cycles from enable accept to dut_reset rise (>=1)
RST_LEN, 4, dut_reset high duration in cycles (>=1)
CNT_W, 32, width of cycle counter and watchdog
TIMEOUT, 1000000, max RUN cycles before timeout; 0 disables watchdog

Ports:
clk  in  1  bench clock
reset  in  1  asynchronous, active-low reset
enable  in  1  level; start sequence when high in IDLE
ch_mask  in  CH  channels that must finish; sampled on enable accept
finish_flag  in  CH  per-channel DUT finish flag (level or pulse)
dut_reset  out  1  active-high reset to DUTs
run_req  out  CH  per-channel run request
cycles  out  CNT_W  cycles spent in RUN
finished  out  CH  sticky per-channel finish latch
done  out  1  all masked channels finished
timeout  out  1  watchdog expired
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; dut_reset=0, run_req=0, cycles=0, finished=0, done=0, timeout=0, busy=0, mask_q=0, timer=0.
- States: IDLE, PRE, RST, RUN, DONE, TMO.
- IDLE: enable=1 -> PRE; mask_q<=ch_mask, timer<=0, finished<=0, cycles<=0, done<=0, timeout<=0. If ch_mask==0 -> DONE directly (done=1 next cycle).
- PRE: timer counts; at timer==RST_START-1 -> RST, timer<=0. dut_reset rises exactly RST_START cycles after the accept edge.
- RST: dut_reset=1; at timer==RST_LEN-1 -> RUN. dut_reset high exactly RST_LEN cycles.
- RUN: dut_reset=0; run_req=mask_q (registered, first high cycle = first RUN cycle). cycles increments every RUN cycle, saturating at all-ones. finished[i] <= finished[i] | (finish_flag[i] & mask_q[i]); unmasked channels never latch and keep run_req=0.
- RUN exit: if (finished|new flags) covers mask_q -> DONE (done=1 the cycle after the last flag is seen). Else if TIMEOUT!=0 and cycles==TIMEOUT-1 -> TMO. Completion and timeout in the same cycle: DONE wins.
- DONE/TMO: run_req=0; done or timeout held high; outputs frozen. enable low -> IDLE (outputs except finished/cycles cleared). enable still high: remain (no auto-restart).
- enable dropping in PRE/RST/RUN: abort to IDLE next cycle, dut_reset and run_req deasserted, done/timeout stay 0.
- finish_flag ignored outside RUN (flags asserted during RST do not latch).
- reset asserted mid-operation: immediate async return to reset values.
- Widths: timer sized $clog2(max(RST_START,RST_LEN))+1; comparisons unsigned.

Optional Feature:
SIM_RUN_SEQ_FINISH_EN: defined -> on entering DONE print "end" plus cycles via $write and call $finish; on TMO print "timeout" plus finished mask then $finish. Undefined -> no system tasks; block fully synthesizable, bench polls done/timeout.

Decomposition:
- Package sim_run_pkg: state enum encoding (IDLE=0..TMO=5), default parameter constants, STATE_W.
- One sub-module natural: sim_run_finish_latch (CH-wide sticky latch + mask-coverage compare, produces all_done). Rest stays in top FSM.

Test Plan:
- CH=4, RST_START=4, RST_LEN=4, ch_mask=4'b1111, enable at cycle 0 -> dut_reset high cycles 4..7, run_req=4'b1111 from cycle 8; flags on ch0..3 at RUN cycles 10,12,15,20 -> done=1 at RUN cycle 21, cycles=21, finished=4'b1111.
- ch_mask=4'b0101, flags only ch0, ch2 -> done; ch1/ch3 flags ignored, run_req=4'b0101, finished=4'b0101.
- TIMEOUT=50, one masked channel never finishes -> timeout=1 after 50 RUN cycles, done=0, finished shows missing channel.
- Last flag on RUN cycle TIMEOUT-1 -> done=1, timeout=0.
- enable dropped during RST -> dut_reset=0 and IDLE next cycle; reset low mid-RUN -> all outputs 0 asynchronously.
- ch_mask=0 -> done=1 one cycle after accept, dut_reset never asserted.

Source files
------------

// File: rtl/sim_run_pkg.sv
// Shared types and default constants for the simulation run sequencer.
// States are encoded IDLE=0 through TMO=5.
package sim_run_pkg;

    localparam int STATE_W         = 3;
    localparam int DEF_CH          = 4;
    localparam int DEF_RST_START   = 4;
    localparam int DEF_RST_LEN     = 4;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT     = 1000000;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_RST  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_TMO  = 3'd5
    } state_e;

endpackage

// File: rtl/sim_run_sequencer_if.sv
// Control/status bundle between the bench controller (master) and the run sequencer (slave).
interface sim_run_sequencer_if
    import sim_run_pkg::*;
#(
    parameter int CH    = DEF_CH,
    parameter int CNT_W = DEF_CNT_W
);

    logic             enable;
    logic [CH-1:0]    ch_mask;
    logic [CH-1:0]    finish_flag;
    logic             dut_reset;
    logic [CH-1:0]    run_req;
    logic [CNT_W-1:0] cycles;
    logic [CH-1:0]    finished;
    logic             done;
    logic             timeout;
    logic             busy;

    modport master (
        output enable, ch_mask, finish_flag,
        input  dut_reset, run_req, cycles, finished, done, timeout, busy
    );

    modport slave (
        input  enable, ch_mask, finish_flag,
        output dut_reset, run_req, cycles, finished, done, timeout, busy
    );

endinterface

// File: rtl/sim_run_finish_latch.sv
// Sticky per-channel finish latch; all_done reports whether the latched flags,
// together with this cycle's flags, cover every masked channel.
module sim_run_finish_latch #(
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          latch_en,
    input  logic [CH-1:0] mask,
    input  logic [CH-1:0] flags,
    output logic [CH-1:0] finished,
    output logic          all_done
);

    logic [CH-1:0] finished_q;
    logic [CH-1:0] finished_d;
    logic [CH-1:0] seen;

    always_comb begin
        seen       = finished_q | (flags & mask & {CH{latch_en}});
        finished_d = clear ? '0 : seen;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            finished_q <= '0;
        end else begin
            finished_q <= finished_d;
        end
    end

    assign finished = finished_q;
    assign all_done = ((seen & mask) == mask);

endmodule

// File: rtl/sim_run_sequencer.sv
// Run sequencer: DUT reset pulse, per-channel run requests, finish aggregation and watchdog.
// Optional macro SIM_RUN_SEQ_FINISH_EN ends the simulation itself on DONE/TMO.
module sim_run_sequencer
    import sim_run_pkg::*;
#(
    parameter int CH        = DEF_CH,
    parameter int RST_START = DEF_RST_START,
    parameter int RST_LEN   = DEF_RST_LEN,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input logic                clk,
    input logic                reset,
    sim_run_sequencer_if.slave bus
);

    localparam int TIMER_W = $clog2((RST_START > RST_LEN) ? RST_START : RST_LEN) + 1;
    localparam logic [TIMER_W-1:0] PRE_LAST = TIMER_W'(RST_START - 1);
    localparam logic [TIMER_W-1:0] RST_LAST = TIMER_W'(RST_LEN - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CH-1:0]    mask_q, mask_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             dut_reset_q, dut_reset_d;
    logic [CH-1:0]    run_req_q, run_req_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             latch_clr;
    logic             latch_en;
    logic             all_done;
    logic [CH-1:0]    finished;

    sim_run_finish_latch #(.CH(CH)) u_finish_latch (
        .clk      (clk),
        .reset    (reset),
        .clear    (latch_clr),
        .latch_en (latch_en),
        .mask     (mask_q),
        .flags    (bus.finish_flag),
        .finished (finished),
        .all_done (all_done)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mask_d    = mask_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        latch_clr = 1'b0;
        latch_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    mask_d    = bus.ch_mask;
                    timer_d   = '0;
                    cycles_d  = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    latch_clr = 1'b1;
                    if (bus.ch_mask == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (timer_q == PRE_LAST) begin
                    state_d = S_RST;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RST: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (timer_q == RST_LAST) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else begin
                    latch_en = 1'b1;
                    if (cycles_q != '1) begin
                        cycles_d = cycles_q + 1'b1;
                    end
                    // Completion is checked first so it beats a watchdog expiry in the same cycle.
                    if (all_done) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if ((TIMEOUT != 0) && (cycles_q == TMO_LAST)) begin
                        state_d   = S_TMO;
                        timeout_d = 1'b1;
                    end
                end
            end
            S_DONE, S_TMO: begin
                if (!bus.enable) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        dut_reset_d = (state_d == S_RST);
        run_req_d   = (state_d == S_RUN) ? mask_d : '0;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            mask_q      <= '0;
            cycles_q    <= '0;
            dut_reset_q <= 1'b0;
            run_req_q   <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mask_q      <= mask_d;
            cycles_q    <= cycles_d;
            dut_reset_q <= dut_reset_d;
            run_req_q   <= run_req_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dut_reset = dut_reset_q;
    assign bus.run_req   = run_req_q;
    assign bus.cycles    = cycles_q;
    assign bus.finished  = finished;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;

`ifdef SIM_RUN_SEQ_FINISH_EN
    state_e prev_q;

    always_ff @(posedge clk) begin
        prev_q <= state_q;
        if (state_q == S_DONE && prev_q != S_DONE) begin
            $write("end %0d\n", cycles_q);
            $finish;
        end
        if (state_q == S_TMO && prev_q != S_TMO) begin
            $write("timeout %b\n", finished);
            $finish;
        end
    end
`else
    // Synthesizable build: the surrounding bench observes done/timeout itself.
`endif

endmodule
